// File: rtl/rgb_led_sequencer.sv
// rgb_led_sequencer: multi-mode LED sequencer (off / step / fade / solid)
// with a programmable step prescaler and PWM brightness per channel.
module rgb_led_sequencer #(
    parameter int NUM_LEDS   = 3,
    parameter int PWM_BITS   = 8,
    parameter int DIV_W      = 24,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                        clock,
    input  logic                        i_reset_n,
    input  logic                        i_enable,
    input  logic [1:0]                  i_mode,
    input  logic [DIV_W-1:0]            i_step_div,
    input  logic [PWM_BITS-1:0]         i_brightness,
    output logic [NUM_LEDS-1:0]         o_leds,
    output logic [$clog2(NUM_LEDS)-1:0] o_active_idx,
    output logic                        o_tick
);

    localparam int IDX_W = $clog2(NUM_LEDS);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_STEP  = 2'd1;
    localparam logic [1:0] MODE_FADE  = 2'd2;
    localparam logic [1:0] MODE_SOLID = 2'd3;

    localparam logic [0:0] ST_UP   = 1'b0;
    localparam logic [0:0] ST_DOWN = 1'b1;

    // Last PWM count is all-ones minus one, so all-ones duty stays lit.
    localparam logic [PWM_BITS-1:0] PWM_LAST =
        {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] LEDS_OFF = {NUM_LEDS{ACTIVE_LOW}};

    logic [DIV_W-1:0]    presc_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] level_q;
    logic [PWM_BITS-1:0] duty_q [NUM_LEDS];
    logic [PWM_BITS-1:0] target [NUM_LEDS];
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_inc;
    logic [0:0]          state_q;
    logic [1:0]          mode_q;
    logic                tick_q;
    logic [NUM_LEDS-1:0] leds_q;
    logic [NUM_LEDS-1:0] lit;
    logic                mode_chg;
    logic                tick;

    assign mode_chg = (i_mode != mode_q);
    // A mode change swallows any coincident tick.
    assign tick     = i_enable && !mode_chg && (presc_q >= i_step_div);
    assign idx_inc  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            target[i] = '0;
            case (mode_q)
                MODE_SOLID: target[i] = i_brightness;
                MODE_STEP: begin
                    if (idx_q == IDX_W'(i)) target[i] = i_brightness;
                end
                MODE_FADE: begin
                    if (idx_q == IDX_W'(i)) target[i] = level_q;
                end
                default: target[i] = '0;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            lit[i] = i_enable && (pwm_cnt_q < duty_q[i]);
        end
    end

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            mode_q  <= MODE_OFF;
        end else begin
            tick_q <= tick;
            mode_q <= i_mode;
            if (mode_chg) begin
                presc_q <= '0;
            end else if (i_enable) begin
                presc_q <= tick ? '0 : presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pwm_cnt_q <= '0;
        end else if (i_enable) begin
            pwm_cnt_q <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
        end
    end

    // Duty only reloads at the period start to avoid mid-period glitches.
    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_LEDS; i++) duty_q[i] <= '0;
        end else if (pwm_cnt_q == '0) begin
            for (int i = 0; i < NUM_LEDS; i++) duty_q[i] <= target[i];
        end
    end

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            leds_q <= LEDS_OFF;
        end else begin
            leds_q <= ACTIVE_LOW ? ~lit : lit;
        end
    end

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            idx_q   <= '0;
            level_q <= '0;
            state_q <= ST_UP;
        end else if (mode_chg) begin
            idx_q   <= '0;
            level_q <= '0;
            state_q <= ST_UP;
        end else if (i_enable) begin
            case (mode_q)
                MODE_STEP: begin
                    if (tick) idx_q <= idx_inc;
                end
                MODE_FADE: begin
                    if (tick) begin
                        case (state_q)
                            ST_UP: begin
                                // Clamp also catches a brightness drop mid-ramp.
                                if (level_q >= i_brightness) begin
                                    state_q <= ST_DOWN;
                                    level_q <= i_brightness;
                                end else begin
                                    level_q <= level_q + 1'b1;
                                end
                            end
                            default: begin
                                if (level_q == '0) begin
                                    idx_q   <= idx_inc;
                                    state_q <= ST_UP;
                                end else begin
                                    level_q <= level_q - 1'b1;
                                end
                            end
                        endcase
                    end
                end
                MODE_SOLID: begin
                    idx_q <= idx_q;
                end
                default: begin
                    idx_q   <= '0;
                    level_q <= '0;
                    state_q <= ST_UP;
                end
            endcase
        end
    end

    assign o_leds       = leds_q;
    assign o_active_idx = idx_q;
    assign o_tick       = tick_q;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// tb_rgb_led_sequencer: random + directed stimulus checked every cycle
// against a behavioural model of the sequencer.
module tb_rgb_led_sequencer;

    localparam int N      = 3;
    localparam int PERIOD = 255;

    logic        clock = 1'b0;
    logic        i_reset_n;
    logic        i_enable;
    logic [1:0]  i_mode;
    logic [23:0] i_step_div;
    logic [7:0]  i_brightness;
    logic [2:0]  o_leds;
    logic [1:0]  o_active_idx;
    logic        o_tick;

    int n_checks = 0;
    int n_fail   = 0;

    int         m_presc;
    int         m_pwm;
    int         m_idx;
    int         m_level;
    bit         m_down;
    int         m_mode_q;
    int         m_duty [N];
    logic [2:0] m_leds;
    bit         m_tick;

    rgb_led_sequencer dut (
        .clock        (clock),
        .i_reset_n    (i_reset_n),
        .i_enable     (i_enable),
        .i_mode       (i_mode),
        .i_step_div   (i_step_div),
        .i_brightness (i_brightness),
        .o_leds       (o_leds),
        .o_active_idx (o_active_idx),
        .o_tick       (o_tick)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp,
                         $time);
        end
    endtask

    function automatic void model_reset();
        m_presc  = 0;
        m_pwm    = 0;
        m_idx    = 0;
        m_level  = 0;
        m_down   = 0;
        m_mode_q = 0;
        m_leds   = 3'b111;
        m_tick   = 0;
        for (int i = 0; i < N; i++) m_duty[i] = 0;
    endfunction

    function automatic int target(int i);
        case (m_mode_q)
            1: return (i == m_idx) ? int'(i_brightness) : 0;
            2: return (i == m_idx) ? m_level : 0;
            3: return int'(i_brightness);
            default: return 0;
        endcase
    endfunction

    // Predicts the outputs after the next rising edge from current inputs.
    function automatic void model_step();
        bit chg;
        bit tk;
        bit en;
        int nd [N];
        int br;
        en  = (i_enable === 1'b1);
        br  = int'(i_brightness);
        chg = (int'(i_mode) != m_mode_q);
        tk  = en && !chg && (m_presc >= int'(i_step_div));
        for (int i = 0; i < N; i++) begin
            m_leds[i] = !(en && (m_pwm < m_duty[i]));
            nd[i] = (m_pwm == 0) ? target(i) : m_duty[i];
        end
        if (chg) m_presc = 0;
        else if (en) m_presc = tk ? 0 : m_presc + 1;
        if (en) m_pwm = (m_pwm + 1) % PERIOD;
        if (chg) begin
            m_idx = 0; m_level = 0; m_down = 0;
        end else if (en) begin
            case (m_mode_q)
                0: begin m_idx = 0; m_level = 0; m_down = 0; end
                1: if (tk) m_idx = (m_idx + 1) % N;
                2: if (tk) begin
                    if (!m_down) begin
                        if (m_level >= br) begin
                            m_down = 1; m_level = br;
                        end else begin
                            m_level++;
                        end
                    end else if (m_level == 0) begin
                        m_idx = (m_idx + 1) % N; m_down = 0;
                    end else begin
                        m_level--;
                    end
                end
                default: ;
            endcase
        end
        for (int i = 0; i < N; i++) m_duty[i] = nd[i];
        m_tick   = tk;
        m_mode_q = int'(i_mode);
    endfunction

    task automatic compare();
        chk("leds", o_leds, m_leds);
        chk("idx", o_active_idx, m_idx);
        chk("tick", o_tick, m_tick);
    endtask

    task automatic run_cycle();
        model_step();
        @(negedge clock);
        compare();
    endtask

    task automatic phase(input int mode, input int div, input int br,
                         input int cycles);
        i_enable     = 1'b1;
        i_mode       = 2'(mode);
        i_step_div   = 24'(div);
        i_brightness = 8'(br);
        repeat (cycles) run_cycle();
    endtask

    task automatic solid_duty(input int br);
        int c;
        phase(3, 0, br, 300);
        c = 0;
        repeat (PERIOD) begin
            run_cycle();
            if (o_leds[0] == 1'b0) c++;
        end
        chk("solid_lit_count", c, br);
    endtask

    task automatic reset_mid_run();
        #3 i_reset_n = 1'b0;
        #1;
        chk("rst_leds", o_leds, 3'b111);
        chk("rst_idx", o_active_idx, 0);
        chk("rst_tick", o_tick, 0);
        model_reset();
        i_mode = 2'd0;
        @(negedge clock);
        compare();
        i_reset_n = 1'b1;
        repeat (10) run_cycle();
    endtask

    function automatic int pick_br();
        case ($urandom_range(0, 4))
            0: return 0;
            1: return 255;
            2: return int'($urandom_range(1, 5));
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        int len;
        i_reset_n    = 1'b0;
        i_enable     = 1'b0;
        i_mode       = 2'd0;
        i_step_div   = '0;
        i_brightness = '0;
        model_reset();
        @(negedge clock);
        compare();
        i_reset_n = 1'b1;
        repeat (5) run_cycle();

        phase(1, 3, 255, 40);
        solid_duty(64);
        solid_duty(0);
        solid_duty(255);

        phase(2, 0, 3, 3);
        i_brightness = 8'd1;
        repeat (12) run_cycle();
        phase(2, 254, 4, 3000);

        phase(1, 100, 255, 50);
        i_step_div = 24'd10;
        repeat (40) run_cycle();

        phase(1, 0, 200, 7);
        phase(2, 0, 200, 10);
        i_enable = 1'b0;
        repeat (20) run_cycle();
        i_enable = 1'b1;
        repeat (20) run_cycle();

        reset_mid_run();

        for (int p = 0; p < 30; p++) begin
            i_mode       = 2'($urandom_range(0, 3));
            i_step_div   = ($urandom_range(0, 3) == 0)
                         ? 24'($urandom_range(0, 300))
                         : 24'($urandom_range(0, 3));
            i_brightness = 8'(pick_br());
            i_enable     = 1'b1;
            len = int'($urandom_range(60, 400));
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 99) < 2) i_enable = ~i_enable;
                if ($urandom_range(0, 199) == 0)
                    i_brightness = 8'(pick_br());
                if ($urandom_range(0, 199) == 0)
                    i_step_div = 24'($urandom_range(0, 12));
                run_cycle();
            end
            if (p == 15) reset_mid_run();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_led_sequencer.md
Name: rgb_led_sequencer

Overview:
Parametrised LED sequencer driving NUM_LEDS LED outputs. It replaces the fixed 2-bit one-hot rotation on a 2^24 counter with four modes (off, step, fade, solid), a programmable step period, and PWM brightness. It sits at top level between board configuration logic and the LED pins.

Parameters:
NUM_LEDS, 3, number of LED channels (≥2)
PWM_BITS, 8, PWM counter and brightness width
DIV_W, 24, step prescaler width
ACTIVE_LOW, 1, 1 = LED lit when output is 0 (board RGB LED); 0 = active-high

Ports:
clock  input  1  system clock
i_reset_n  input  1  asynchronous active-low reset
i_enable  input  1  1 = run; 0 = freeze all counters and force all LEDs unlit
i_mode  input  2  0 OFF, 1 STEP, 2 FADE, 3 SOLID
i_step_div  input  DIV_W  step tick period minus 1, in clocks
i_brightness  input  PWM_BITS  peak duty
o_leds  output  NUM_LEDS  LED drive, polarity set by ACTIVE_LOW
o_active_idx  output  $clog2(NUM_LEDS)  index of the current LED in STEP/FADE
o_tick  output  1  one-cycle pulse on each step tick

Behaviour:
- Reset: asynchronous on i_reset_n low; deassertion is assumed synchronised upstream. While in reset, all state clears: o_leds all unlit (all 1s if ACTIVE_LOW), o_active_idx = 0, o_tick = 0, prescaler = 0, pwm_cnt = 0, level = 0, fade state = UP, duty registers = 0, mode_q = 0.
- Prescaler:
  - Counts 0..i_step_div while i_enable = 1.
  - When count ≥ i_step_div: tick asserts, count returns to 0. Using ≥ means lowering i_step_div below the current count gives a tick next cycle instead of a 2^DIV_W wrap.
  - i_step_div = 0 gives a tick every cycle.
  - o_tick is registered: it goes high the cycle after the tick condition, for exactly 1 cycle.
- PWM:
  - pwm_cnt counts 0..2^PWM_BITS−2 and wraps, so the period is 2^PWM_BITS−1 clocks.
  - Channel lit when pwm_cnt < duty_q[i]. Duty 0 = never lit; duty all-ones = always lit.
  - duty_q[i] loads the target duty only on cycles where pwm_cnt = 0, so there are no mid-period glitches.
  - o_leds is registered from the compare (1 cycle latency), then inverted if ACTIVE_LOW.
- Target duty per mode:
  - OFF: all 0. idx = 0, level = 0, state = UP.
  - SOLID: all channels = i_brightness.
  - STEP: channel idx = i_brightness, others 0. On each tick idx += 1; NUM_LEDS−1 wraps to 0.
  - FADE: channel idx = level, others 0. Two-state FSM:
    - UP, on tick: if level ≥ i_brightness, go to DOWN and set level = i_brightness (clamp, covers a mid-ramp brightness drop); else level += 1.
    - DOWN, on tick: if level = 0, advance idx (with wrap) and go to UP; else level −= 1.
    - With i_brightness = 0, each LED consumes 2 ticks.
- Mode change: when i_mode ≠ mode_q (registered copy), that cycle forces idx = 0, level = 0, state = UP, prescaler = 0 and no tick. mode_q then updates.
- Enable: i_enable = 0 holds the prescaler, pwm_cnt, idx, level and state. o_leds goes unlit on the next cycle and o_tick = 0. Re-enabling resumes from the held state.
- Simultaneous mode change and tick: the mode change wins and the tick is dropped.

Test Plan:
1. Reset mid-run: assert i_reset_n low asynchronously, between clock edges → o_leds = 3'b111 immediately, o_active_idx = 0, o_tick = 0. Release → LEDs stay unlit until a mode is selected.
2. STEP, i_step_div = 3, i_brightness = 8'hFF, ACTIVE_LOW = 1 → o_tick every 4 clocks. o_active_idx sequence 0,1,2,0. Active LED output held at 0, others at 1.
3. SOLID, i_brightness = 64 → each channel lit exactly 64 of every 255 clocks. i_brightness = 0 → never lit. i_brightness = 255 → always lit. A brightness change mid-period takes effect only at the next pwm_cnt = 0.
4. FADE, i_step_div = 0, i_brightness = 3 → level on idx 0 is 0,1,2,3,3,2,1,0, then idx = 1. Drop i_brightness to 1 while level = 2 in UP → next tick gives DOWN with level = 1.
5. i_step_div = 100 with count = 50, change to 10 → o_tick the cycle after the change, then every 11 clocks.
6. Change i_mode STEP→FADE with idx = 2, coincident with a tick → idx = 0, level = 0, no o_tick that cycle. i_enable = 0 for 20 clocks → LEDs unlit, idx/level frozen, resumes on re-enable.
